// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide engine: iterative shift-add MULTU, restoring DIV/DIVU with sign fix-up.
// Optional macro HILO_FAST_MULTU_EN turns MULTU into a single-cycle combinational multiply.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div,
  input  logic             divu,
  input  logic             multu,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             cancel,
  input  logic [WIDTH-1:0] rsdata,
  input  logic [WIDTH-1:0] rtdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  // acc: partial remainder / product high; sh: quotient / multiplier-product low
  logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, opnd_q, opnd_d;
  logic             sgn_q, sgn_d, negq_q, negq_d, negr_q, negr_d, dz_q, dz_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_sh;
  logic             is_div;

`ifdef HILO_FAST_MULTU_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, rsdata} * {{WIDTH{1'b0}}, rtdata};
`endif

  assign is_div = div | divu;

  always_comb begin
    mul_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
    div_rem  = {acc_q, sh_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_q};
    div_acc  = div_diff[WIDTH] ? div_rem[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_sh   = {sh_q[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;

    if (cancel && state_q != StIdle) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!cancel) begin
            if (is_div) begin
              // div wins over divu; signed ops work on magnitudes
              state_d = StDiv;
              busy_d  = 1'b1;
              cnt_d   = '0;
              acc_d   = '0;
              sgn_d   = div;
              dz_d    = (rtdata == '0);
              negq_d  = div & (rsdata[WIDTH-1] ^ rtdata[WIDTH-1]);
              negr_d  = div & rsdata[WIDTH-1];
              sh_d    = (div && rsdata[WIDTH-1] && rtdata != '0) ? -rsdata : rsdata;
              opnd_d  = (div && rtdata[WIDTH-1]) ? -rtdata : rtdata;
            end else if (multu) begin
`ifdef HILO_FAST_MULTU_EN
              hi_d = fast_prod[2*WIDTH-1:WIDTH];
              lo_d = fast_prod[WIDTH-1:0];
`else
              state_d = StMul;
              busy_d  = 1'b1;
              cnt_d   = '0;
              acc_d   = '0;
              sh_d    = rtdata;
              opnd_d  = rsdata;
`endif
            end else if (mthi) begin
              hi_d = rsdata;
            end else if (mtlo) begin
              lo_d = rsdata;
            end
          end
        end
        StMul: begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            hi_d    = mul_sum[WIDTH:1];
            lo_d    = {mul_sum[0], sh_q[WIDTH-1:1]};
            state_d = StIdle;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end
        StDiv: begin
          if (dz_q) begin
            hi_d    = sh_q;
            lo_d    = '1;
            state_d = StIdle;
            busy_d  = 1'b0;
          end else begin
            acc_d = div_acc;
            sh_d  = div_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              cnt_d = '0;
              if (sgn_q) begin
                state_d = StFix;
              end else begin
                hi_d    = div_acc;
                lo_d    = div_sh;
                state_d = StIdle;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StFix: begin
          hi_d    = negr_q ? -acc_q : acc_q;
          lo_d    = negq_q ? -sh_q : sh_q;
          state_d = StIdle;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = StIdle;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus queues expected hi/lo/busy-length,
// a negedge monitor pops and compares when busy falls or an explicit observe strobe fires.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, div, divu, multu, mthi, mtlo, cancel;
  logic [31:0] rsdata, rtdata;
  logic [31:0] hi, lo;
  logic        busy;

  hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .div(div), .divu(divu), .multu(multu),
    .mthi(mthi), .mtlo(mtlo), .cancel(cancel), .rsdata(rsdata), .rtdata(rtdata),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;  // -1: observe-strobe check, busy must be 0
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic obs = 1'b0;
  logic busy_prev = 1'b0;
  int   bcnt = 0;

  always begin
    @(negedge clk);
    if (busy === 1'b1) bcnt++;
    if ((busy_prev === 1'b1 && busy === 1'b0) || obs) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output hi=%h lo=%h busy=%b required no event", hi, lo, busy);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (hi !== e.hi) begin
          errors++;
          $display("FAIL chk%0d_hi actual=%h required=%h", e.id, hi, e.hi);
        end
        checks++;
        if (lo !== e.lo) begin
          errors++;
          $display("FAIL chk%0d_lo actual=%h required=%h", e.id, lo, e.lo);
        end
        checks++;
        if (e.cyc >= 0 && bcnt != e.cyc) begin
          errors++;
          $display("FAIL chk%0d_busy_cycles actual=%0d required=%0d", e.id, bcnt, e.cyc);
        end else if (e.cyc < 0 && busy !== 1'b0) begin
          errors++;
          $display("FAIL chk%0d_busy actual=%b required=0", e.id, busy);
        end
      end
      bcnt = 0;
    end
    busy_prev = busy;
  end

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input int cyc,
                            input int id);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = cyc; e.id = id;
    exp_q.push_back(e);
  endtask

  // Drive a request for exactly one edge (that edge is E0); returns at E0+1.
  task automatic issue(input logic d, input logic du, input logic mu, input logic h,
                       input logic l, input logic [31:0] rs, input logic [31:0] rt);
    div = d; divu = du; multu = mu; mthi = h; mtlo = l; rsdata = rs; rtdata = rt;
    @(posedge clk); #1;
    div = 0; divu = 0; multu = 0; mthi = 0; mtlo = 0;
  endtask

  task automatic observe();
    obs = 1'b1;
    @(posedge clk); #1;
    obs = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL chk%0d_timeout busy=%b required=0 after %0d cycles", id, busy, n);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_multu(input logic [31:0] rs, input logic [31:0] rt, input logic h,
                          input logic [31:0] eh, input logic [31:0] el, input int id);
`ifdef HILO_FAST_MULTU_EN
    expect_res(eh, el, -1, id);
    issue(0, 0, 1, h, 0, rs, rt);
    observe();
`else
    expect_res(eh, el, 32, id);
    issue(0, 0, 1, h, 0, rs, rt);
    wait_idle(id);
`endif
  endtask

  initial begin
    rst = 1; div = 0; divu = 0; multu = 0; mthi = 0; mtlo = 0; cancel = 0;
    rsdata = 0; rtdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    expect_res(32'h0, 32'h0, -1, 1);
    observe();

    expect_res(32'd2, 32'd14, 32, 2);
    issue(0, 1, 0, 0, 0, 32'd100, 32'd7);
    wait_idle(2);

    // div has priority over divu
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 3);
    issue(1, 1, 0, 0, 0, 32'hFFFF_FFF9, 32'd2);
    wait_idle(3);

    expect_res(32'h0, 32'h8000_0000, 33, 4);
    issue(1, 0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(4);

    expect_res(32'd1, 32'hFFFF_FFFD, 33, 5);
    issue(1, 0, 0, 0, 0, 32'd7, 32'hFFFF_FFFE);
    wait_idle(5);

    do_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 6);

    expect_res(32'h1234_5678, 32'hFFFF_FFFF, 1, 7);
    issue(0, 1, 0, 0, 0, 32'h1234_5678, 32'h0);
    wait_idle(7);

    expect_res(32'hFFFF_FFF9, 32'hFFFF_FFFF, 1, 8);
    issue(1, 0, 0, 0, 0, 32'hFFFF_FFF9, 32'h0);
    wait_idle(8);

    issue(0, 0, 0, 1, 0, 32'hAAAA_0000, 32'h0);
    issue(0, 0, 0, 0, 1, 32'h0000_5555, 32'h0);
    expect_res(32'hAAAA_0000, 32'h0000_5555, -1, 9);
    observe();

    // cancel lands on E10: busy seen high for 10 cycles, hi/lo untouched
    expect_res(32'hAAAA_0000, 32'h0000_5555, 10, 10);
    issue(0, 1, 0, 0, 0, 32'd9, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1;
    @(posedge clk); #1;
    cancel = 0;
    wait_idle(10);

    expect_res(32'h0, 32'h0, 10, 11);
    issue(0, 1, 0, 0, 0, 32'd9, 32'd4);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    wait_idle(11);

    // mthi during a running divu is ignored
    expect_res(32'd6, 32'd142, 32, 12);
    issue(0, 1, 0, 0, 0, 32'd1000, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    issue(0, 0, 0, 1, 0, 32'h0000_DEAD, 32'h0);
    wait_idle(12);

    // multu beats mthi
    do_multu(32'd3, 32'd5, 1, 32'h0, 32'd15, 13);

    // mthi beats mtlo
    issue(0, 0, 0, 1, 1, 32'h77, 32'h0);
    expect_res(32'h77, 32'd15, -1, 14);
    observe();

    // cancel in idle blocks a same-edge request
    cancel = 1;
    issue(0, 1, 0, 0, 0, 32'd9, 32'd4);
    cancel = 0;
    expect_res(32'h77, 32'd15, -1, 15);
    observe();

    expect_res(32'h0, 32'hFFFF_FFFF, 32, 16);
    issue(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1);
    wait_idle(16);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide engine that owns the HI/LO register pair of the 54-instruction MIPS core.
- Sits downstream of the control-signal decoder. It consumes the one-hot DIV, DIVU, MULTU, MTHI and MTLO flags plus the rs/rt operand values.
- Supplies hi/lo to the MFHI/MFLO write-back path (M7 select).
- Raises busy so the fetch/PC logic stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand width; hi and lo are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- div  input  1  signed divide request (decoded DIV)
- divu  input  1  unsigned divide request (decoded DIVU)
- multu  input  1  unsigned multiply request (decoded MULTU)
- mthi  input  1  load hi from rsdata
- mtlo  input  1  load lo from rsdata
- cancel  input  1  abort the running operation (exception flush)
- rsdata  input  WIDTH  rs operand (dividend / multiplicand / MTxx source)
- rtdata  input  WIDTH  rt operand (divisor / multiplier)
- hi  output  WIDTH  HI register: remainder or product[63:32]
- lo  output  WIDTH  LO register: quotient or product[31:0]
- busy  output  1  registered; high while an operation is in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: hi=0, lo=0, busy=0, state=IDLE, counter=0. Reset aborts any in-flight operation.
- States:
  - IDLE: accepts requests.
  - MUL: shift-add multiply.
  - DIV: restoring divide on magnitudes.
  - FIX: signed sign-correction, DIV only.
- Request acceptance: requests are sampled only in IDLE, at the edge where a request is high (edge E0). Operands are latched at E0. Requests while busy=1 are ignored; the core stalls on busy, so none are expected.
- Priority when several requests are high together: div > divu > multu > mthi > mtlo.
- MTHI/MTLO: in IDLE, hi or lo is written with rsdata at E0. Single cycle; busy stays 0.
- MULTU:
  - E0: IDLE->MUL, busy=1.
  - Edges E1..E32: one shift-add step per edge.
  - E32: {hi,lo} = 64-bit unsigned product; busy=0; state->IDLE.
- DIVU:
  - E0: IDLE->DIV, busy=1.
  - Edges E1..E32: one restoring step per edge.
  - E32: lo = quotient, hi = remainder; busy=0.
- DIV:
  - Magnitudes of both operands are taken at E0, followed by 32 DIV steps.
  - E33 (FIX): quotient is negated if the operand signs differ; remainder takes the sign of the dividend. Results are written; busy=0.
  - Total busy time: 33 cycles.
- Overflow: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This is the natural result; no trap.
- Divide by zero (div or divu with rtdata=0): completes at E1 with lo=0xFFFFFFFF, hi=rsdata, busy=0 after E1. No exception is raised.
- Result visibility: hi/lo are unchanged until the final edge of an operation. Intermediate values live in internal shadow registers. MFHI/MFLO issued after busy falls sees the new values.
- cancel:
  - While busy: the next edge returns to IDLE with busy=0. hi and lo keep their pre-operation values.
  - In IDLE: cancel has priority over requests at the same edge; no request is accepted.
- rst is checked before cancel, and cancel before requests.
- Counter: counts from 0 up to WIDTH-1. It is never observable and never wraps past WIDTH.

Optional Feature:
- Macro: HILO_FAST_MULTU_EN
- Defined: MULTU completes at E0 as a single-cycle combinational 32x32 multiply written directly to {hi,lo}. busy never asserts for MULTU and the MUL state is unused.
- Undefined: iterative 32-cycle MULTU as described above.
- DIV/DIVU timing is identical in both builds.

Test Plan:
- divu=1, rs=100, rt=7 -> busy high for 32 cycles; then lo=14, hi=2, busy=0.
- div=1, rs=0xFFFFFFF9 (-7), rt=2 -> busy high for 33 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Also rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- multu=1, rs=rt=0xFFFFFFFF -> after 32 cycles (1 cycle with HILO_FAST_MULTU_EN): hi=0xFFFFFFFE, lo=0x00000001.
- divu=1, rs=0x12345678, rt=0 -> next cycle lo=0xFFFFFFFF, hi=0x12345678, busy=0.
- mthi rs=0xAAAA0000 then mtlo rs=0x5555; start divu 9/4; pulse cancel at cycle 10 -> busy=0 next cycle, hi=0xAAAA0000, lo=0x5555 unchanged. Repeat the run with rst at cycle 10 instead -> hi=lo=0.
- During a running DIVU, assert mthi with rs=0xDEAD -> ignored. Final hi equals the remainder, not 0xDEAD.
